ifu_fb_ctl: RTL and testbench

// Fetch buffer on the consumer side of the fetch pipe. Captures each F2 fetch group returned by the ICache/ICCM

---
 rtl/ifu_fb_ctl.sv | 101 ++++++++++
 tb/tb_ifu_fb_ctl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fb_ctl.sv
// rtl/ifu_fb_ctl.sv - circular fetch buffer between F2 fetch groups and the aligner
// Presents the two oldest fetch groups and frees entries on aligner consume pulses.
module ifu_fb_ctl #(
    parameter int FB_DEPTH = 4,
    parameter int DATA_W   = 64
) (
    input  logic                          clk,
    input  logic                          rst_l,
    input  logic                          exu_flush_final,
    input  logic                          fb_wr_en_f2,
    input  logic [30:0]                   fb_wr_addr_f2,
    input  logic [DATA_W-1:0]             fb_wr_data_f2,
    input  logic                          ifu_fb_consume1,
    input  logic                          ifu_fb_consume2,
    output logic                          fb_valid0,
    output logic                          fb_valid1,
    output logic [30:0]                   fb_addr0,
    output logic [30:0]                   fb_addr1,
    output logic [DATA_W-1:0]             fb_data0,
    output logic [DATA_W-1:0]             fb_data1,
    output logic [$clog2(FB_DEPTH):0]     fb_count,
    output logic                          fb_full,
    output logic                          fb_empty,
    output logic                          fb_err_overflow,
    output logic                          fb_err_underflow
);
    localparam int PW = $clog2(FB_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FB_DEPTH);

    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr1;
    logic [CW-1:0]     count;
    logic [30:0]       addr_mem [FB_DEPTH];
    logic [DATA_W-1:0] data_mem [FB_DEPTH];
    logic              err_of;
    logic              err_uf;

    logic [CW-1:0]     c_req;
    logic [CW-1:0]     c_amt;
    logic [CW-1:0]     remaining;
    logic              underflow;
    logic              accept;
    logic              drop;

    // Consume is clamped to occupancy first, so a write may reuse a slot freed this cycle.
    always_comb begin
        c_req     = '0;
        if (ifu_fb_consume2)
            c_req = CW'(2);
        else if (ifu_fb_consume1)
            c_req = CW'(1);
        underflow = c_req > count;
        c_amt     = underflow ? count : c_req;
        remaining = count - c_amt;
        accept    = fb_wr_en_f2 && (remaining < DEPTH_C);
        drop      = fb_wr_en_f2 && !accept;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            err_of <= 1'b0;
            err_uf <= 1'b0;
        end else if (exu_flush_final) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + c_amt[PW-1:0];
            wr_ptr <= wr_ptr + PW'(accept);
            count  <= remaining + CW'(accept);
            err_of <= err_of | drop;
            err_uf <= err_uf | underflow;
        end
    end

    always_ff @(posedge clk) begin
        if (!exu_flush_final && accept) begin
            addr_mem[wr_ptr] <= fb_wr_addr_f2;
            data_mem[wr_ptr] <= fb_wr_data_f2;
        end
    end

    // Invalid entries read as zero so the outputs are clean during reset.
    assign rd_ptr1          = rd_ptr + PW'(1);
    assign fb_valid0        = (count != '0);
    assign fb_valid1        = (count >= CW'(2));
    assign fb_addr0         = fb_valid0 ? addr_mem[rd_ptr]  : '0;
    assign fb_addr1         = fb_valid1 ? addr_mem[rd_ptr1] : '0;
    assign fb_data0         = fb_valid0 ? data_mem[rd_ptr]  : '0;
    assign fb_data1         = fb_valid1 ? data_mem[rd_ptr1] : '0;
    assign fb_count         = count;
    assign fb_full          = (count == DEPTH_C);
    assign fb_empty         = (count == '0);
    assign fb_err_overflow  = err_of;
    assign fb_err_underflow = err_uf;
endmodule

// File: tb/tb_ifu_fb_ctl.sv
// tb/tb_ifu_fb_ctl.sv - directed and random checks of ifu_fb_ctl against a queue model
module tb_ifu_fb_ctl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [30:0] wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        cons1 = 1'b0;
    logic        cons2 = 1'b0;
    logic        valid0, valid1, full, empty, err_of, err_uf;
    logic [30:0] addr0, addr1;
    logic [63:0] data0, data1;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [30:0] a;
        logic [63:0] d;
    } ent_t;
    ent_t q[$];
    logic m_of = 1'b0;
    logic m_uf = 1'b0;

    ifu_fb_ctl #(.FB_DEPTH(DEPTH), .DATA_W(64)) dut (
        .clk(clk), .rst_l(rst_l), .exu_flush_final(flush),
        .fb_wr_en_f2(wr_en), .fb_wr_addr_f2(wr_addr), .fb_wr_data_f2(wr_data),
        .ifu_fb_consume1(cons1), .ifu_fb_consume2(cons2),
        .fb_valid0(valid0), .fb_valid1(valid1),
        .fb_addr0(addr0), .fb_addr1(addr1),
        .fb_data0(data0), .fb_data1(data1),
        .fb_count(count), .fb_full(full), .fb_empty(empty),
        .fb_err_overflow(err_of), .fb_err_underflow(err_uf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: a plain FIFO queue with clamped consume and bounded push.
    task automatic model_step(input logic wr, input logic [30:0] a, input logic [63:0] d,
                              input logic c1, input logic c2, input logic fl);
        int c;
        ent_t e;
        if (fl) begin
            q.delete();
        end else begin
            c = c2 ? 2 : (c1 ? 1 : 0);
            if (c > q.size()) begin
                m_uf = 1'b1;
                c = q.size();
            end
            for (int i = 0; i < c; i++) void'(q.pop_front());
            if (wr) begin
                if (q.size() < DEPTH) begin
                    e.a = a;
                    e.d = d;
                    q.push_back(e);
                end else begin
                    m_of = 1'b1;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = q.size();
        chk({tag, "_count"}, count, n);
        chk({tag, "_full"}, full, n == DEPTH);
        chk({tag, "_empty"}, empty, n == 0);
        chk({tag, "_valid0"}, valid0, n >= 1);
        chk({tag, "_valid1"}, valid1, n >= 2);
        chk({tag, "_err_of"}, err_of, m_of);
        chk({tag, "_err_uf"}, err_uf, m_uf);
        if (n >= 1) begin
            chk({tag, "_addr0"}, addr0, q[0].a);
            chk({tag, "_data0"}, data0, q[0].d);
        end
        if (n >= 2) begin
            chk({tag, "_addr1"}, addr1, q[1].a);
            chk({tag, "_data1"}, data1, q[1].d);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_valid0"}, valid0, 0);
        chk({tag, "_valid1"}, valid1, 0);
        chk({tag, "_addr0"}, addr0, 0);
        chk({tag, "_addr1"}, addr1, 0);
        chk({tag, "_data0"}, data0, 0);
        chk({tag, "_data1"}, data1, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_err_of"}, err_of, 0);
        chk({tag, "_err_uf"}, err_uf, 0);
    endtask

    task automatic step(input logic wr, input logic [30:0] a, input logic [63:0] d,
                        input logic c1, input logic c2, input logic fl, input string tag);
        wr_en = wr; wr_addr = a; wr_data = d;
        cons1 = c1; cons2 = c2; flush = fl;
        @(posedge clk);
        model_step(wr, a, d, c1, c2, fl);
        #1;
        check_model(tag);
        wr_en = 1'b0; cons1 = 1'b0; cons2 = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        #2 rst_l = 1'b0;
        #1;
        q.delete();
        m_of = 1'b0;
        m_uf = 1'b0;
        check_zero(tag);
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    initial begin
        logic [63:0] head_d;
        #3;
        check_zero("reset");
        @(negedge clk);
        rst_l = 1'b1;

        // 1: fill
        for (int i = 0; i < 4; i++)
            step(1, 31'h100 + 31'(8 * i), 64'hA0 + 64'(i), 0, 0, 0, "t1");
        chk("t1_count4", count, 4);
        chk("t1_full", full, 1);
        chk("t1_addr0", addr0, 31'h100);
        chk("t1_addr1", addr1, 31'h108);

        // 2: write into slot freed the same cycle
        step(1, 31'h120, 64'hA4, 1, 0, 0, "t2");
        chk("t2_count", count, 4);
        chk("t2_addr0", addr0, 31'h108);
        chk("t2_tail", q[3].a, 31'h120);
        chk("t2_no_of", err_of, 0);

        // 3: underflow from count=1
        step(0, 0, 0, 0, 1, 0, "t3a");
        step(0, 0, 0, 1, 0, 0, "t3b");
        chk("t3_count1", count, 1);
        step(0, 0, 0, 0, 1, 0, "t3c");
        chk("t3_count0", count, 0);
        chk("t3_uf", err_uf, 1);
        step(0, 0, 0, 0, 0, 0, "t3d");
        chk("t3_valid0", valid0, 0);

        // 4: flush wins over write and consume
        do_reset("t4rst");
        for (int i = 0; i < 3; i++)
            step(1, 31'h200 + 31'(8 * i), 64'hB0 + 64'(i), 0, 0, 0, "t4a");
        step(1, 31'h2F0, 64'hBF, 1, 0, 1, "t4b");
        chk("t4_count", count, 0);
        chk("t4_of", err_of, 0);
        chk("t4_uf", err_uf, 0);
        step(1, 31'h300, 64'hC0, 0, 0, 0, "t4c");
        chk("t4_entry0", addr0, 31'h300);

        // 5: wrap-around with interleaved consumes
        for (int i = 0; i < 6; i++)
            step(1, 31'h400 + 31'(8 * i), 64'hD0 + 64'(i), i > 0, 0, 0, "t5");
        step(0, 0, 0, 0, 0, 0, "t5end");

        // 6: overflow keeps head intact
        while (q.size() < DEPTH)
            step(1, 31'h500 + 31'(8 * q.size()), 64'hE0 + 64'(q.size()), 0, 0, 0, "t6a");
        head_d = q[0].d;
        step(1, 31'h5F0, 64'hEF, 0, 0, 0, "t6b");
        chk("t6_of", err_of, 1);
        chk("t6_head", data0, head_d);

        // random phase
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, 31'($urandom), {$urandom, $urandom},
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 29) == 0, "rnd");

        // async reset mid-stream, away from the clock edge
        for (int i = 0; i < 3; i++)
            step(1, 31'h600 + 31'(8 * i), 64'hF0 + 64'(i), 0, 0, 0, "t7a");
        do_reset("t7rst");
        step(1, 31'h700, 64'h77, 0, 0, 0, "t7b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
